// File: rtl/icache_refill_server_pkg.sv
// Shared cache geometry for the ICache refill path: block length and width.
package icache_refill_server_pkg;

  localparam int BLK_LEN  = 4;
  localparam int BLK_SIZE = BLK_LEN * 32;

  typedef logic [1:0] word_t;

endpackage

// File: rtl/icache_refill_server_if.sv
// ICache refill bus plus backing-RAM read port; slave is the refill server.
interface icache_refill_server_if #(
  parameter int ADDR_W = 13
);
  import icache_refill_server_pkg::*;

  logic [3:0]          mem_ren;
  logic [31:0]         mem_raddr;
  logic                mem_rrdy;
  logic                mem_rvalid;
  logic [BLK_SIZE-1:0] mem_rdata;
  logic                ram_en;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_rdata;

  modport slave (
    input  mem_ren, mem_raddr, ram_rdata,
    output mem_rrdy, mem_rvalid, mem_rdata, ram_en, ram_addr
  );

  modport master (
    output mem_ren, mem_raddr, ram_rdata,
    input  mem_rrdy, mem_rvalid, mem_rdata, ram_en, ram_addr
  );

endinterface

// File: rtl/icache_refill_server.sv
// Fetches one 4-word block from RAM per request, words 0..3 in order; 4*(RD_LAT+1) cycles
// accept-to-valid. Accepts only in IDLE (mem_rrdy); requests while busy are dropped, not queued.
module icache_refill_server
  import icache_refill_server_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 13
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  icache_refill_server_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LAST  = 3'(RD_LAT - 1);
  localparam word_t      LAST_WORD = 2'(BLK_LEN - 1);

  state_t              r_state;
  word_t               r_word;
  logic [2:0]          r_lat;
  logic [ADDR_W-3:0]   r_base;
  logic                r_rrdy;
  logic                r_rvalid;
  logic                r_ram_en;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [BLK_SIZE-1:0] r_rdata;

  logic                w_accept;
  logic [ADDR_W-3:0]   w_req_base;
  logic                w_unused_raddr;

  assign w_accept       = r_rrdy & (|io_bus.mem_ren);
  assign w_req_base     = io_bus.mem_raddr[ADDR_W+1:4];
  assign w_unused_raddr = ^{io_bus.mem_raddr[31:ADDR_W+2], io_bus.mem_raddr[3:0]};

  // Outputs are registered from the next state, so they line up with r_state.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_lat      <= '0;
      r_base     <= '0;
      r_rrdy     <= 1'b1;
      r_rvalid   <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_addr <= '0;
      r_rdata    <= '0;
    end else begin
      r_rrdy   <= 1'b0;
      r_rvalid <= 1'b0;
      r_ram_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rrdy <= 1'b1;
          if (w_accept) begin
            r_state    <= S_ISSUE;
            r_rrdy     <= 1'b0;
            r_base     <= w_req_base;
            r_word     <= '0;
            r_ram_en   <= 1'b1;
            r_ram_addr <= {w_req_base, 2'b00};
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_lat   <= '0;
        end
        S_WAIT: begin
          r_lat <= r_lat + 3'd1;
          if (r_lat == LAT_LAST) begin
            r_rdata[{r_word, 5'd0} +: 32] <= io_bus.ram_rdata;
            r_word <= r_word + 2'd1;
            if (r_word == LAST_WORD) begin
              r_state  <= S_RESP;
              r_rvalid <= 1'b1;
            end else begin
              // Lane index is appended to the base, so the block never carries upward.
              r_state    <= S_ISSUE;
              r_ram_en   <= 1'b1;
              r_ram_addr <= {r_base, r_word + 2'd1};
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_rrdy  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_rrdy  <= 1'b1;
        end
      endcase
    end
  end

  assign io_bus.mem_rrdy   = r_rrdy;
  assign io_bus.mem_rvalid = r_rvalid;
  assign io_bus.mem_rdata  = r_rdata;
  assign io_bus.ram_en     = r_ram_en;
  assign io_bus.ram_addr   = r_ram_addr;

endmodule

// File: tb/tb_icache_refill_server.sv
// Scoreboard bench: directed refill requests on an RD_LAT=1 and an RD_LAT=3 instance.
module tb_icache_refill_server;
  import icache_refill_server_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_refill_server_if #(.ADDR_W(13)) a_if ();
  icache_refill_server_if #(.ADDR_W(13)) b_if ();

  icache_refill_server #(.RD_LAT(1), .ADDR_W(13)) dut_a (
    .cpu_clk(clk), .cpu_rst(rst), .io_bus(a_if)
  );
  icache_refill_server #(.RD_LAT(3), .ADDR_W(13)) dut_b (
    .cpu_clk(clk), .cpu_rst(rst), .io_bus(b_if)
  );

  // RAM models: word k reads 0xA000_0000+k, RD_LAT cycles after ram_en; garbage otherwise
  logic        a_v = 1'b0;
  logic [12:0] a_a = '0;
  logic [2:0]  b_v = '0;
  logic [12:0] b_a [3];
  always @(posedge clk) begin
    a_v    <= a_if.ram_en;
    a_a    <= a_if.ram_addr;
    b_v    <= {b_v[1:0], b_if.ram_en};
    b_a[2] <= b_a[1];
    b_a[1] <= b_a[0];
    b_a[0] <= b_if.ram_addr;
  end
  assign a_if.ram_rdata = a_v    ? (32'hA000_0000 | {19'd0, a_a})    : 32'hDEAD_BEEF;
  assign b_if.ram_rdata = b_v[2] ? (32'hA000_0000 | {19'd0, b_a[2]}) : 32'hDEAD_BEEF;

  logic [127:0] qa_dat[$], qb_dat[$];
  logic [12:0]  qa_adr[$], qb_adr[$];
  int           qa_acc[$], qb_acc[$];
  bit           pa = 1'b0, pb = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: unexpected event or bound expired at cycle %0d", nm, cyc);
  endtask

  task automatic push_a(input logic [10:0] base, input logic [127:0] dat);
    for (int k = 0; k < 4; k++) qa_adr.push_back({base, 2'(k)});
    qa_dat.push_back(dat);
  endtask

  task automatic push_b(input logic [10:0] base, input logic [127:0] dat);
    for (int k = 0; k < 4; k++) qb_adr.push_back({base, 2'(k)});
    qb_dat.push_back(dat);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pa) begin
        chk("a_rvalid_one_cycle", a_if.mem_rvalid, 0);
        chk("a_rrdy_after_rvalid", a_if.mem_rrdy, 1);
      end
      if (a_if.ram_en) begin
        if (qa_adr.size() == 0) fail_now("a_extra_ram_en");
        else chk("a_ram_addr", a_if.ram_addr, qa_adr.pop_front());
      end
      if (a_if.mem_rvalid) begin
        if (qa_dat.size() == 0 || qa_acc.size() == 0) fail_now("a_unexpected_rvalid");
        else begin
          chk("a_rdata", a_if.mem_rdata, qa_dat.pop_front());
          chk("a_latency", cyc, qa_acc.pop_front() + 8);
        end
      end
      if (a_if.mem_rrdy && a_if.mem_ren != 4'h0) qa_acc.push_back(cyc + 1);
      pa = a_if.mem_rvalid;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pb) begin
        chk("b_rvalid_one_cycle", b_if.mem_rvalid, 0);
        chk("b_rrdy_after_rvalid", b_if.mem_rrdy, 1);
      end
      if (b_if.ram_en) begin
        if (qb_adr.size() == 0) fail_now("b_extra_ram_en");
        else chk("b_ram_addr", b_if.ram_addr, qb_adr.pop_front());
      end
      if (b_if.mem_rvalid) begin
        if (qb_dat.size() == 0 || qb_acc.size() == 0) fail_now("b_unexpected_rvalid");
        else begin
          chk("b_rdata", b_if.mem_rdata, qb_dat.pop_front());
          chk("b_latency", cyc, qb_acc.pop_front() + 16);
        end
      end
      if (b_if.mem_rrdy && b_if.mem_ren != 4'h0) qb_acc.push_back(cyc + 1);
      pb = b_if.mem_rvalid;
    end
  end

  task automatic req_a(input logic [3:0] ren, input logic [31:0] addr);
    @(posedge clk); #1;
    a_if.mem_ren   = ren;
    a_if.mem_raddr = addr;
    @(posedge clk); #1;
    a_if.mem_ren   = 4'h0;
  endtask

  task automatic wait_idle_a(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk); #1;
      if (qa_dat.size() == 0 && qa_adr.size() == 0 && a_if.mem_rrdy) done = 1'b1;
    end
    if (!done) fail_now("a_idle_timeout");
  endtask

  task automatic wait_idle_b(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk); #1;
      if (qb_dat.size() == 0 && qb_adr.size() == 0 && b_if.mem_rrdy) done = 1'b1;
    end
    if (!done) fail_now("b_idle_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.mem_ren = 4'h0; a_if.mem_raddr = '0;
    b_if.mem_ren = 4'h0; b_if.mem_raddr = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_rrdy",     a_if.mem_rrdy,   1);
    chk("rst_rvalid",   a_if.mem_rvalid, 0);
    chk("rst_ram_en",   a_if.ram_en,     0);
    chk("rst_ram_addr", a_if.ram_addr,   0);
    chk("rst_rdata",    a_if.mem_rdata,  0);

    // Request presented together with reset release: accepted at the first edge.
    for (int k = 0; k < 4; k++) qa_adr.push_back(13'h48 + 13'(k));
    qa_dat.push_back(128'hA000004B_A000004A_A0000049_A0000048);
    rst = 1'b0;
    a_if.mem_ren = 4'hF; a_if.mem_raddr = 32'h0000_0124;
    @(posedge clk); #1;
    a_if.mem_ren = 4'h0;
    wait_idle_a(40);

    // Low offset bits ignored: full block from word 0.
    push_a(11'h000, 128'hA0000003_A0000002_A0000001_A0000000);
    req_a(4'h1, 32'h0000_000C);
    wait_idle_a(40);

    // Held request: exactly two transfers.
    push_a(11'h004, 128'hA0000013_A0000012_A0000011_A0000010);
    push_a(11'h004, 128'hA0000013_A0000012_A0000011_A0000010);
    @(posedge clk); #1;
    a_if.mem_ren = 4'hF; a_if.mem_raddr = 32'h0000_0040;
    repeat (20) @(posedge clk); #1;
    a_if.mem_ren = 4'h0;
    wait_idle_a(60);

    // Request mid-transfer is dropped.
    push_a(11'h020, 128'hA0000083_A0000082_A0000081_A0000080);
    req_a(4'hF, 32'h0000_0200);
    repeat (2) @(posedge clk); #1;
    chk("a_rrdy_busy", a_if.mem_rrdy, 0);
    a_if.mem_ren = 4'hF; a_if.mem_raddr = 32'h0000_0080;
    @(posedge clk); #1;
    a_if.mem_ren = 4'h0;
    wait_idle_a(40);

    // Reset mid-transfer abandons it immediately.
    push_a(11'h010, 128'hA0000043_A0000042_A0000041_A0000040);
    req_a(4'hF, 32'h0000_0100);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_rrdy",   a_if.mem_rrdy,   1);
    chk("midrst_rvalid", a_if.mem_rvalid, 0);
    chk("midrst_ram_en", a_if.ram_en,     0);
    chk("midrst_rdata",  a_if.mem_rdata,  0);
    qa_adr.delete(); qa_dat.delete(); qa_acc.delete();
    pa = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    push_a(11'h001, 128'hA0000007_A0000006_A0000005_A0000004);
    req_a(4'hF, 32'h0000_0010);
    wait_idle_a(40);

    // Upper address bits beyond the RAM are dropped; top block of RAM.
    push_a(11'h7FF, 128'hA0001FFF_A0001FFE_A0001FFD_A0001FFC);
    req_a(4'h2, 32'hFFFF_FFF0);
    wait_idle_a(40);

    // RD_LAT=3 instance.
    push_b(11'h7FF, 128'hA0001FFF_A0001FFE_A0001FFD_A0001FFC);
    @(posedge clk); #1;
    b_if.mem_ren = 4'hF; b_if.mem_raddr = 32'h0000_7FF0;
    @(posedge clk); #1;
    b_if.mem_ren = 4'h0;
    wait_idle_b(60);

    repeat (3) @(posedge clk); #1;
    chk("a_sb_empty", 128'(qa_dat.size() + qa_adr.size() + qa_acc.size()), 0);
    chk("b_sb_empty", 128'(qb_dat.size() + qb_adr.size() + qb_acc.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
